// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared parity codes and frame-checker state encodings
//
// Purpose: constants and types used by the UART RX frame checker.
//   PAR_NONE/PAR_EVEN/PAR_ODD : parity_mode codes (code 3 also means none)
//   frame_state_t             : frame checker FSM states
//   parity_on()               : true when a mode code asks for a parity check

package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'd0;
    localparam logic [1:0] PAR_EVEN = 2'd1;
    localparam logic [1:0] PAR_ODD  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_STOP2   = 2'd2,
        ST_DONE    = 2'd3
    } frame_state_t;

    function automatic logic parity_on(input logic [1:0] mode);
        return (mode == PAR_EVEN) || (mode == PAR_ODD);
    endfunction

endpackage

// File: rtl/uart_majority_vote.sv
// rtl/uart_majority_vote.sv - oversampled RX line majority voter
//
// Purpose: keeps the last VOTE_N line samples and reports the majority value.
// Ports:
//   clk          in   clock
//   rst          in   asynchronous active-low reset (register goes all-ones = idle line)
//   serial_in    in   synchronised RX line
//   sample_tick  in   shift serial_in into the vote register this cycle
//   voted        out  1 when more than VOTE_N/2 stored samples are 1
// voted is combinational from the register, so a consumer sampling it in the
// same cycle as sample_tick sees the pre-shift majority.

module uart_majority_vote #(
    parameter int VOTE_N = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic serial_in,
    input  logic sample_tick,
    output logic voted
);

    localparam int CW = $clog2(VOTE_N + 1);
    localparam logic [CW-1:0] HALF = CW'(VOTE_N / 2);

    logic [VOTE_N-1:0] vote_sr;
    logic [CW-1:0]     ones;

    generate
        if (VOTE_N == 1) begin : g_single
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vote_sr <= '1;
                end else if (sample_tick) begin
                    vote_sr <= serial_in;
                end
            end
        end else begin : g_shift
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    vote_sr <= '1;
                end else if (sample_tick) begin
                    vote_sr <= {vote_sr[VOTE_N-2:0], serial_in};
                end
            end
        end
    endgenerate

    always_comb begin
        ones = '0;
        for (int i = 0; i < VOTE_N; i++) begin
            ones = ones + CW'(vote_sr[i]);
        end
        voted = (ones > HALF);
    end

endmodule

// File: rtl/uart_frame_check.sv
// rtl/uart_frame_check.sv - UART RX frame checker: parity, 1/2 stop bits, error counters
//
// Purpose: runs beside the UART RX FSM, votes each oversampled bit, accumulates
// data parity, checks the parity bit and one or two stop bits, and reports a
// one-cycle frame result plus saturating error counters.
// Ports:
//   clk, rst                 clock, asynchronous active-low reset
//   serial_in, sample_tick   RX line and sample strobe into the voter
//   frame_start              start bit seen; clears per-frame state, latches mode
//   data_bit_en              voted bit is a data bit
//   par_chk_en               voted bit is the parity bit
//   stop_chk_en              voted bit is a stop bit
//   parity_mode[1:0]         0 none, 1 even, 2 odd, 3 none
//   stop_bits_2              1 = two stop bits
//   err_clr                  zero both error counters
//   stop_error, par_error    flags of the current / last frame
//   frame_done, frame_valid  one-cycle result pulse and its no-error qualifier
//   stop_err_cnt, par_err_cnt  saturating per-frame error counts

module uart_frame_check
    import uart_pkg::*;
#(
    parameter int VOTE_N = 3,
    parameter int CNT_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             sample_tick,
    input  logic             frame_start,
    input  logic             data_bit_en,
    input  logic             par_chk_en,
    input  logic             stop_chk_en,
    input  logic [1:0]       parity_mode,
    input  logic             stop_bits_2,
    input  logic             err_clr,
    output logic             stop_error,
    output logic             par_error,
    output logic             frame_done,
    output logic             frame_valid,
    output logic [CNT_W-1:0] stop_err_cnt,
    output logic [CNT_W-1:0] par_err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    frame_state_t state, state_nx;

    logic             voted;
    logic [1:0]       mode_q;
    logic             stop2_q;
    logic             par_acc;
    logic             stop_err_q;
    logic             par_err_q;
    logic [CNT_W-1:0] stop_cnt_q;
    logic [CNT_W-1:0] par_cnt_q;

    logic in_frame;
    logic stop_hit;
    logic par_hit;
    logic data_hit;

    uart_majority_vote #(
        .VOTE_N (VOTE_N)
    ) u_vote (
        .clk         (clk),
        .rst         (rst),
        .serial_in   (serial_in),
        .sample_tick (sample_tick),
        .voted       (voted)
    );

    // Enable qualification: frame_start masks everything, and only the
    // highest-priority strobe of stop > parity > data is acted on.
    always_comb begin
        in_frame = (state == ST_COLLECT) || (state == ST_STOP2);
        stop_hit = in_frame && stop_chk_en && !frame_start;
        par_hit  = (state == ST_COLLECT) && par_chk_en && !stop_chk_en && !frame_start;
        data_hit = (state == ST_COLLECT) && data_bit_en && !stop_chk_en && !par_chk_en
                   && !frame_start;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        if (frame_start) begin
            state_nx = ST_COLLECT;
        end else begin
            case (state)
                ST_COLLECT: if (stop_hit) state_nx = stop2_q ? ST_STOP2 : ST_DONE;
                ST_STOP2:   if (stop_hit) state_nx = ST_DONE;
                ST_DONE:    state_nx = ST_IDLE;
                default:    state_nx = ST_IDLE;
            endcase
        end
    end

    // Per-frame flags and latched frame format. The format is captured only at
    // frame_start so the RX side may retune parity_mode/stop_bits_2 mid-frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode_q     <= PAR_NONE;
            stop2_q    <= 1'b0;
            par_acc    <= 1'b0;
            stop_err_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else if (frame_start) begin
            mode_q     <= parity_mode;
            stop2_q    <= stop_bits_2;
            par_acc    <= 1'b0;
            stop_err_q <= 1'b0;
            par_err_q  <= 1'b0;
        end else begin
            if (data_hit) begin
                par_acc <= par_acc ^ voted;
            end
            if (par_hit && parity_on(mode_q)) begin
                par_err_q <= par_acc ^ voted ^ (mode_q == PAR_ODD);
            end
            if (stop_hit) begin
                stop_err_q <= stop_err_q | ~voted;
            end
        end
    end

    // Counters count frames, not bits: they move only in the DONE cycle, which
    // still happens when a new frame_start coincides with it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stop_cnt_q <= '0;
            par_cnt_q  <= '0;
        end else if (err_clr) begin
            stop_cnt_q <= '0;
            par_cnt_q  <= '0;
        end else if (state == ST_DONE) begin
            if (stop_err_q && (stop_cnt_q != CNT_MAX)) begin
                stop_cnt_q <= stop_cnt_q + CNT_W'(1);
            end
            if (par_err_q && (par_cnt_q != CNT_MAX)) begin
                par_cnt_q <= par_cnt_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        frame_done   = (state == ST_DONE);
        frame_valid  = (state == ST_DONE) && !(stop_err_q || par_err_q);
        stop_error   = stop_err_q;
        par_error    = par_err_q;
        stop_err_cnt = stop_cnt_q;
        par_err_cnt  = par_cnt_q;
    end

endmodule

// File: tb/tb_uart_frame_check.sv
// tb/tb_uart_frame_check.sv - self-checking bench for uart_frame_check

module tb_uart_frame_check;
    import uart_pkg::*;

    localparam int VN = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       serial_in = 1'b1;
    logic       sample_tick = 1'b0;
    logic       frame_start = 1'b0;
    logic       data_bit_en = 1'b0;
    logic       par_chk_en = 1'b0;
    logic       stop_chk_en = 1'b0;
    logic [1:0] parity_mode = 2'd0;
    logic       stop_bits_2 = 1'b0;
    logic       err_clr = 1'b0;

    logic       d8_stop_error, d8_par_error, d8_frame_done, d8_frame_valid;
    logic [7:0] d8_stop_cnt, d8_par_cnt;
    logic       d2_stop_error, d2_par_error, d2_frame_done, d2_frame_valid;
    logic [1:0] d2_stop_cnt, d2_par_cnt;

    uart_frame_check #(.VOTE_N(VN), .CNT_W(8)) u_dut (
        .clk(clk), .rst(rst), .serial_in(serial_in), .sample_tick(sample_tick),
        .frame_start(frame_start), .data_bit_en(data_bit_en), .par_chk_en(par_chk_en),
        .stop_chk_en(stop_chk_en), .parity_mode(parity_mode), .stop_bits_2(stop_bits_2),
        .err_clr(err_clr), .stop_error(d8_stop_error), .par_error(d8_par_error),
        .frame_done(d8_frame_done), .frame_valid(d8_frame_valid),
        .stop_err_cnt(d8_stop_cnt), .par_err_cnt(d8_par_cnt)
    );

    uart_frame_check #(.VOTE_N(VN), .CNT_W(2)) u_dut2 (
        .clk(clk), .rst(rst), .serial_in(serial_in), .sample_tick(sample_tick),
        .frame_start(frame_start), .data_bit_en(data_bit_en), .par_chk_en(par_chk_en),
        .stop_chk_en(stop_chk_en), .parity_mode(parity_mode), .stop_bits_2(stop_bits_2),
        .err_clr(err_clr), .stop_error(d2_stop_error), .par_error(d2_par_error),
        .frame_done(d2_frame_done), .frame_valid(d2_frame_valid),
        .stop_err_cnt(d2_stop_cnt), .par_err_cnt(d2_par_cnt)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Reference model: line-sample history, latest frame flags, counters.
    bit hist[$];
    bit m_se, m_pe;
    int c8s, c8p, c2s, c2p;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    function automatic bit maj();
        int ones = 0;
        foreach (hist[i]) ones += int'(hist[i]);
        return ones > VN / 2;
    endfunction

    task automatic push(input bit s);
        hist.push_back(s);
        while (hist.size() > VN) void'(hist.pop_front());
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    function automatic logic [VN-1:0] mk(input logic b, input bit noise);
        logic [VN-1:0] s;
        s = {VN{b}};
        if (noise && ($urandom_range(0, 1) == 1)) s[$urandom_range(0, VN - 1)] = ~b;
        return s;
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < VN; i++) hist.push_back(1'b1);
        m_se = 0; m_pe = 0;
        c8s = 0; c8p = 0; c2s = 0; c2p = 0;
    endtask

    task automatic clear_inputs();
        sample_tick = 0; data_bit_en = 0; par_chk_en = 0; stop_chk_en = 0;
        frame_start = 0; err_clr = 0;
    endtask

    // Send VN samples (smp[0] first) then the strobe of the given kind
    // (0 data, 1 parity, 2 stop); v returns the majority the strobe should see.
    task automatic send_bit(input logic [VN-1:0] smp, input int kind, output bit v);
        bit co;
        bit co_en;
        for (int k = 0; k < VN; k++) begin
            serial_in = smp[k];
            sample_tick = 1;
            cyc();
            push(smp[k]);
        end
        sample_tick = 0;
        v = maj();
        case (kind)
            0: data_bit_en = 1;
            1: par_chk_en = 1;
            default: stop_chk_en = 1;
        endcase
        co_en = ($urandom_range(0, 1) == 1);
        co = $urandom_range(0, 1);
        if (co_en) begin
            serial_in = co;
            sample_tick = 1;
        end
        if (kind >= 1 && $urandom_range(0, 3) == 0) data_bit_en = 1;
        if (kind == 2 && $urandom_range(0, 3) == 0) par_chk_en = 1;
        cyc();
        if (co_en) push(co);
        clear_inputs();
    endtask

    task automatic finish_done(input bit se, input bit pe, input bit clr, input bit start);
        check("done8", d8_frame_done, 1);
        check("done2", d2_frame_done, 1);
        check("valid", d8_frame_valid, !(se || pe));
        check("stop_err", d8_stop_error, se);
        check("par_err", d8_par_error, pe);
        if (clr) err_clr = 1;
        if (start) begin
            frame_start = 1;
            parity_mode = $urandom;
            stop_bits_2 = $urandom;
        end
        cyc();
        clear_inputs();
        if (clr) begin
            c8s = 0; c8p = 0; c2s = 0; c2p = 0;
        end else begin
            if (se) begin c8s = sat(c8s + 1, 255); c2s = sat(c2s + 1, 3); end
            if (pe) begin c8p = sat(c8p + 1, 255); c2p = sat(c2p + 1, 3); end
        end
        m_se = start ? 1'b0 : se;
        m_pe = start ? 1'b0 : pe;
        check("done_after", d8_frame_done, 0);
        check("cnt8_stop", d8_stop_cnt, c8s);
        check("cnt8_par", d8_par_cnt, c8p);
        check("cnt2_stop", d2_stop_cnt, c2s);
        check("cnt2_par", d2_par_cnt, c2p);
        check("flag_stop_after", d8_stop_error, m_se);
        check("flag_par_after", d8_par_error, m_pe);
    endtask

    task automatic send_frame(input logic [7:0] data, input int nbits, input logic [1:0] mode,
                              input logic st2, input logic pbit, input logic [VN-1:0] s1v,
                              input logic [VN-1:0] s2v, input bit noise, input bit clr,
                              input bit start);
        bit v, se, pe;
        int ones;
        frame_start = 1; parity_mode = mode; stop_bits_2 = st2;
        cyc();
        frame_start = 0;
        parity_mode = $urandom; stop_bits_2 = $urandom;
        check("start_clr_stop", d8_stop_error, 0);
        check("start_clr_par", d8_par_error, 0);
        ones = 0;
        for (int i = 0; i < nbits; i++) begin
            send_bit(mk(data[i], noise), 0, v);
            ones += int'(v);
        end
        pe = 0;
        if (mode == PAR_EVEN || mode == PAR_ODD) begin
            send_bit(mk(pbit, noise), 1, v);
            ones += int'(v);
            pe = (mode == PAR_EVEN) ? (ones % 2 != 0) : (ones % 2 == 0);
        end else if ($urandom_range(0, 1) == 1) begin
            send_bit(mk(pbit, noise), 1, v);
        end
        check("mid_done", d8_frame_done, 0);
        send_bit(s1v, 2, v);
        se = !v;
        if (st2) begin
            check("stop2_wait", d8_frame_done, 0);
            send_bit(s2v, 2, v);
            se = se || !v;
        end
        finish_done(se, pe, clr, start);
    endtask

    localparam logic [VN-1:0] ONES = '1;
    localparam logic [VN-1:0] ZERO = '0;

    initial begin
        bit v, se;
        int ones;
        logic [7:0] d;
        model_reset();
        clear_inputs();
        #3;
        check("rst_done", d8_frame_done, 0);
        check("rst_valid", d8_frame_valid, 0);
        check("rst_stop", d8_stop_error, 0);
        check("rst_par", d8_par_error, 0);
        check("rst_cnt_s", d8_stop_cnt, 0);
        check("rst_cnt_p", d8_par_cnt, 0);
        cyc();
        rst = 1;
        cyc();

        // Stop bit checked with no samples: vote register is still idle-high.
        frame_start = 1; parity_mode = PAR_NONE; stop_bits_2 = 0;
        cyc();
        clear_inputs();
        se = !maj();
        stop_chk_en = 1;
        cyc();
        clear_inputs();
        finish_done(se, 0, 0, 0);

        send_frame(8'h55, 8, PAR_EVEN, 0, 0, ONES, ONES, 0, 0, 0);
        send_frame(8'h01, 8, PAR_ODD, 0, 1, ONES, ONES, 1, 0, 0);
        send_frame(8'hA3, 8, PAR_NONE, 1, 0, ONES, ZERO, 0, 0, 0);
        send_frame(8'hA3, 8, PAR_NONE, 1, 0, ZERO, ONES, 0, 0, 0);
        send_frame(8'h3C, 8, PAR_NONE, 0, 0, 3'b101, ONES, 0, 0, 0);
        send_frame(8'h3C, 8, PAR_NONE, 0, 0, 3'b100, ONES, 0, 0, 0);

        // Five more bad frames: the 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) send_frame($urandom, 8, PAR_EVEN, 0, 1, ZERO, ONES, 1, 0, 0);
        check("sat2", d2_stop_cnt, 3);
        send_frame($urandom, 8, PAR_NONE, 0, 0, ZERO, ONES, 0, 1, 0);

        // Abort mid-frame after a parity error became visible.
        send_frame(8'h00, 8, PAR_NONE, 0, 0, ZERO, ONES, 0, 0, 0);
        frame_start = 1; parity_mode = PAR_EVEN; stop_bits_2 = 0;
        cyc();
        clear_inputs();
        d = 8'h07;
        ones = 0;
        for (int i = 0; i < 8; i++) begin
            send_bit(mk(d[i], 0), 0, v);
            ones += int'(v);
        end
        send_bit(mk(1'b0, 0), 1, v);
        ones += int'(v);
        check("abort_par_set", d8_par_error, ones % 2);
        frame_start = 1;
        cyc();
        clear_inputs();
        check("abort_clr_par", d8_par_error, 0);
        check("abort_clr_stop", d8_stop_error, 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("abort_no_done", d8_frame_done, 0);
            check("abort_cnt_s", d8_stop_cnt, c8s);
            check("abort_cnt_p", d8_par_cnt, c8p);
        end
        send_frame(8'h5A, 8, PAR_ODD, 0, 1, ONES, ONES, 0, 0, 0);

        // Asynchronous reset in the middle of a frame.
        frame_start = 1; parity_mode = PAR_EVEN; stop_bits_2 = 1;
        cyc();
        clear_inputs();
        send_bit(mk(1'b1, 0), 0, v);
        send_bit(mk(1'b0, 0), 0, v);
        #2 rst = 0;
        #1;
        check("mrst_stop", d8_stop_error, 0);
        check("mrst_par", d8_par_error, 0);
        check("mrst_done", d8_frame_done, 0);
        check("mrst_valid", d8_frame_valid, 0);
        check("mrst_cnt_s", d8_stop_cnt, 0);
        check("mrst_cnt2_s", d2_stop_cnt, 0);
        cyc();
        rst = 1;
        model_reset();

        for (int n = 0; n < 40; n++) begin
            logic [VN-1:0] s1v, s2v;
            bit start;
            s1v = ($urandom_range(0, 3) == 0) ? VN'($urandom) : ONES;
            s2v = ($urandom_range(0, 3) == 0) ? VN'($urandom) : ONES;
            start = ($urandom_range(0, 5) == 0);
            send_frame($urandom, $urandom_range(5, 8), $urandom_range(0, 3), $urandom_range(0, 1),
                       $urandom_range(0, 1), s1v, s2v, 1, $urandom_range(0, 7) == 0, start);
            if (!start) begin
                for (int k = 0; k < 3; k++) begin
                    bit tk, sv, clr;
                    tk = $urandom_range(0, 1);
                    sv = $urandom_range(0, 1);
                    clr = ($urandom_range(0, 7) == 0);
                    serial_in = sv; sample_tick = tk;
                    data_bit_en = $urandom; par_chk_en = $urandom; stop_chk_en = $urandom;
                    err_clr = clr;
                    cyc();
                    clear_inputs();
                    if (tk) push(sv);
                    if (clr) begin c8s = 0; c8p = 0; c2s = 0; c2p = 0; end
                    check("idle_stop", d8_stop_error, m_se);
                    check("idle_par", d8_par_error, m_pe);
                    check("idle_done", d8_frame_done, 0);
                    check("idle_cnt_s", d8_stop_cnt, c8s);
                    check("idle_cnt2_p", d2_par_cnt, c2p);
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
